lockin_demod: RTL and testbench
===============================

// Module: lockin_demod
// PURPOSE
//  Lock-in demodulation stage wrapped around the quarter-sine DDS core.
//  - Per ADC sample: advance a 32-bit phase accumulator, pulse the DDS, wait for sin/cos, then mix.
//  - Mixing: I = sample*cos, Q = sample*sin.
//  - Integrate-and-dump decimation over DEC samples gives filtered I/Q results at a reduced rate for readout.
// PARAMETERS
//  DEC      1024  samples per integrate-and-dump output (>=1)
//  SHIFT    16    arithmetic right shift applied to accumulators before output
//  DDS_LAT  3     cycles waited after dds_go deasserts before dds_sin/dds_cos are captured
//  ACC_W    48    accumulator width (signed)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active high
//  adc_data   in   16  signed two's-complement input sample
//  adc_valid  in   1   one-cycle strobe, adc_data valid
//  ftw        in   32  frequency tuning word, phase increment per sample
//  dds_go     out  1   one-cycle pulse starting a DDS lookup
//  dds_phase  out  18  phase to DDS (= phase_acc[31:14])
//  dds_sin    in   16  DDS sine, signed two's complement
//  dds_cos    in   16  DDS cosine, signed two's complement
//  i_out      out  24  signed in-phase result
//  q_out      out  24  signed quadrature result
//  out_valid  out  1   one-cycle strobe, i_out/q_out updated
//  busy       out  1   high while a sample is in flight
//  overrun    out  1   sticky: adc_valid arrived while busy; cleared only by rst
// BEHAVIOUR
//  Reset
//  - Synchronous, active high.
//  - All outputs, phase_acc, accumulators, dec_cnt, wait counter and FSM clear to 0 / IDLE.
//  - Reset mid-operation aborts the lookup: no out_valid, partial sum discarded.
//  FSM states: IDLE -> GO -> WAIT -> MAC -> IDLE
//  - IDLE
//    - adc_valid=1: latch adc_data; dds_go<=1; busy<=1; go to GO.
//    - Otherwise stay.
//  - GO (1 cycle)
//    - dds_go<=0; wait cnt<=0; go to WAIT.
//    - dds_go is therefore high exactly one cycle, so the DDS always sees a fresh rising edge.
//  - WAIT (DDS_LAT cycles)
//    - On the last WAIT cycle, register dds_sin/dds_cos; go to MAC.
//  - MAC (1 cycle)
//    - p_i = sample*cos, p_q = sample*sin: signed 16x16 -> 32 bits, sign-extended to ACC_W.
//    - Accumulate both products.
//    - phase_acc <= phase_acc + ftw: unsigned, wraps mod 2^32; ftw sampled this cycle.
//    - dec_cnt += 1; busy<=0; go to IDLE.
//  Phase hold
//  - dds_phase is constant from the GO cycle through MAC.
//  - The DDS reads phase on multiple cycles; a change mid-lookup corrupts sin/cos.
//  - The sample is mixed with the pre-increment phase.
//  Throughput
//  - busy lasts DDS_LAT+2 cycles; minimum sample spacing is DDS_LAT+3 cycles.
//  - adc_valid while busy: sample dropped, overrun<=1, FSM unaffected.
//  - adc_valid in the same cycle MAC returns to IDLE: dropped and overrun set (IDLE is not yet active).
//  Dump, when dec_cnt reaches DEC in MAC
//  - i_out/q_out <= saturate24((acc + p) >>> SHIFT).
//  - Saturation limits: 0x7FFFFF / 0x800000.
//  - out_valid pulses the following cycle.
//  - Accumulators clear to 0 and dec_cnt to 0; no sample is lost across a dump.
//  - i_out/q_out hold their value between dumps.
//  Arithmetic
//  - All products and sums are signed.
//  - The shift is arithmetic and truncating (floor).
//  - The accumulator cannot overflow for DEC <= 2^(ACC_W-32).
// TESTING
//  1. DEC=4, SHIFT=8, stub sin=0, cos=0x7FFF, adc=1000 x4 -> i_out=511984, q_out=0, one out_valid.
//  2. ftw=0x40000000, 4 samples -> dds_phase = 0x00000, 0x10000, 0x20000, 0x30000; then wraps to 0x00000.
//  3. adc=-32768, sin=cos=0x8000, DEC=4, SHIFT=8 -> i_out=q_out=0x7FFFFF (saturated).
//  4. adc_valid spaced 2 cycles apart -> second sample dropped, overrun=1 and stays 1, dec_cnt +1 only.
//  5. Check dds_go width=1 and dds_phase stable GO..MAC; bench DDS model with 3-cycle latency -> sin/cos match model.
//  6. Assert rst during WAIT -> next cycle all outputs 0, FSM IDLE, no out_valid; next sample processes normally.

Source files
------------

// File: rtl/lockin_demod.sv
// Lock-in demodulator: steps a phase accumulator once per ADC sample, fetches sin/cos from an
// external DDS, mixes the sample into I/Q and integrate-and-dumps every DEC samples.
//
//  state | meaning
//  IDLE  | waiting for adc_valid
//  GO    | dds_go high for one cycle, DDS samples dds_phase
//  WAIT  | DDS_LAT cycles of DDS latency, sin/cos captured on the last one
//  MAC   | multiply-accumulate, phase step, optional dump
module lockin_demod #(
    parameter int DEC     = 1024,
    parameter int SHIFT   = 16,
    parameter int DDS_LAT = 3,
    parameter int ACC_W   = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] adc_data,
    input  logic        adc_valid,
    input  logic [31:0] ftw,
    output logic        dds_go,
    output logic [17:0] dds_phase,
    input  logic [15:0] dds_sin,
    input  logic [15:0] dds_cos,
    output logic [23:0] i_out,
    output logic [23:0] q_out,
    output logic        out_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int CNT_W = (DDS_LAT > 1) ? $clog2(DDS_LAT) : 1;
    localparam int DEC_W = (DEC > 1) ? $clog2(DEC) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(DDS_LAT - 1);
    localparam logic [DEC_W-1:0] DEC_LAST  = DEC_W'(DEC - 1);

    typedef enum logic [1:0] {IDLE, GO, WAIT, MAC} state_t;

    state_t state, state_nxt;
    logic   take, capture, mac;

    logic        [31:0]      phase_acc;
    logic        [CNT_W-1:0] wait_cnt;
    logic        [DEC_W-1:0] dec_cnt;
    logic signed [15:0]      sample, sin_r, cos_r;
    logic signed [ACC_W-1:0] acc_i, acc_q;
    logic signed [31:0]      p_i, p_q;
    logic signed [ACC_W-1:0] sum_i, sum_q, sh_i, sh_q;
    logic                    unused_phase_lsb;

    function automatic logic [23:0] sat24(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-24:0] top;
        top = v[ACC_W-1:23];
        if ((&top) || !(|top)) return v[23:0];
        else if (v[ACC_W-1])  return 24'h800000;
        else                  return 24'h7FFFFF;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        capture   = 1'b0;
        mac       = 1'b0;
        case (state)
            IDLE: if (adc_valid) begin
                take      = 1'b1;
                state_nxt = GO;
            end
            GO:   state_nxt = WAIT;
            WAIT: if (wait_cnt == WAIT_LAST) begin
                capture   = 1'b1;
                state_nxt = MAC;
            end
            MAC: begin
                mac       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dds_go    = (state == GO);
    assign busy      = (state != IDLE);
    assign dds_phase = phase_acc[31:14];
    assign unused_phase_lsb = ^phase_acc[13:0];

    assign p_i   = sample * cos_r;
    assign p_q   = sample * sin_r;
    assign sum_i = acc_i + {{(ACC_W-32){p_i[31]}}, p_i};
    assign sum_q = acc_q + {{(ACC_W-32){p_q[31]}}, p_q};
    assign sh_i  = sum_i >>> SHIFT;
    assign sh_q  = sum_q >>> SHIFT;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_acc <= '0;
            wait_cnt  <= '0;
            dec_cnt   <= '0;
            sample    <= '0;
            sin_r     <= '0;
            cos_r     <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (adc_valid && busy) overrun <= 1'b1;
            if (take) sample <= adc_data;
            if (state == GO)        wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
            if (capture) begin
                sin_r <= dds_sin;
                cos_r <= dds_cos;
            end
            if (mac) begin
                // phase steps only after the mix, so the sample uses the pre-increment phase
                phase_acc <= phase_acc + ftw;
                if (dec_cnt == DEC_LAST) begin
                    i_out     <= sat24(sh_i);
                    q_out     <= sat24(sh_q);
                    out_valid <= 1'b1;
                    acc_i     <= '0;
                    acc_q     <= '0;
                    dec_cnt   <= '0;
                end else begin
                    acc_i   <= sum_i;
                    acc_q   <= sum_q;
                    dec_cnt <= dec_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lockin_demod.sv
// Bench for lockin_demod: DDS model with 3-cycle latency, scoreboard of expected dumps.
module tb_lockin_demod;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic [31:0] ftw;
    logic        dds_go;
    logic [17:0] dds_phase;
    logic [15:0] dds_sin, dds_cos;
    logic [23:0] i_out, q_out;
    logic        out_valid, busy, overrun;

    typedef struct packed { logic [23:0] i; logic [23:0] q; } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_phase = 32'h0;

    bit          use_func = 1'b0;
    logic [15:0] stub_sin = 16'h0, stub_cos = 16'h0;
    int          dcnt;
    logic [17:0] lph;

    always #5 clk = ~clk;

    lockin_demod #(.DEC(4), .SHIFT(8), .DDS_LAT(3), .ACC_W(48)) dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid), .ftw(ftw),
        .dds_go(dds_go), .dds_phase(dds_phase), .dds_sin(dds_sin), .dds_cos(dds_cos),
        .i_out(i_out), .q_out(q_out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    function automatic logic signed [15:0] fsin(input logic [17:0] p);
        return p[17:2] ^ 16'h3C5A;
    endfunction

    function automatic logic signed [15:0] fcos(input logic [17:0] p);
        return p[15:0] + 16'h1111;
    endfunction

    function automatic logic [23:0] sat24(input longint v);
        longint s;
        s = v >>> 8;
        if (s > 64'sd8388607)  return 24'h7FFFFF;
        if (s < -64'sd8388608) return 24'h800000;
        return s[23:0];
    endfunction

    // DDS model: phase read at the dds_go edge, data valid only in the third cycle after
    always @(posedge clk) begin
        if (rst) dcnt <= 0;
        else if (dds_go) begin
            dcnt <= 1;
            lph  <= dds_phase;
        end else if (dcnt != 0 && dcnt < 3) dcnt <= dcnt + 1;
        else dcnt <= 0;
    end

    always_comb begin
        dds_sin = 16'h7E7E;
        dds_cos = 16'h7E7E;
        if (dcnt == 3) begin
            if (use_func) begin
                dds_sin = fsin(lph);
                dds_cos = fcos(lph);
            end else begin
                dds_sin = stub_sin;
                dds_cos = stub_cos;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("i_out", i_out, e.i);
                chk("q_out", q_out, e.q);
            end
        end
    end

    // drop_at: busy cycle (1=GO .. 5=MAC) in which an extra adc_valid is raised, 0 for none
    task automatic send(input logic [15:0] d, input int drop_at);
        logic [17:0] ph;
        int n;
        bit go_bad, ph_bad;
        adc_data  = d;
        adc_valid = 1'b1;
        @(posedge clk); #1;
        adc_valid = 1'b0;
        chk("go_high", dds_go, 1);
        chk("phase", dds_phase, exp_phase[31:14]);
        ph = dds_phase;
        n = 1; go_bad = 0; ph_bad = 0;
        forever begin
            if (n == drop_at) begin
                adc_data  = 16'd30000;
                adc_valid = 1'b1;
            end
            @(posedge clk); #1;
            adc_valid = 1'b0;
            if (!busy || n >= 20) break;
            n++;
            if (dds_go) go_bad = 1;
            if (dds_phase != ph) ph_bad = 1;
        end
        chk("busy_len", n, 5);
        chk("go_width", go_bad, 0);
        chk("phase_hold", ph_bad, 0);
        exp_phase = exp_phase + ftw;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [15:0] v5 [4];
        logic [31:0] p;
        longint ai, aq;

        rst = 1'b1; adc_data = '0; adc_valid = 1'b0; ftw = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_i_out", i_out, 0);
        chk("rst_q_out", q_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_dds_go", dds_go, 0);
        chk("rst_dds_phase", dds_phase, 0);

        // 1: constant cos, DC input
        stub_sin = 16'h0000; stub_cos = 16'h7FFF;
        exp_q.push_back({24'd511984, 24'd0});
        for (int k = 0; k < 4; k++) send(16'd1000, 0);

        // 2: quarter-turn phase steps, wrap back to zero
        ftw = 32'h40000000; stub_sin = 16'd1; stub_cos = 16'd2;
        exp_q.push_back({24'd3, 24'd1});
        for (int k = 0; k < 4; k++) send(16'd100, 0);
        chk("phase_wrap", dds_phase, 0);

        // 3: saturation at both rails
        ftw = 32'h0; stub_sin = 16'h8000; stub_cos = 16'h8000;
        exp_q.push_back({24'h7FFFFF, 24'h7FFFFF});
        for (int k = 0; k < 4; k++) send(16'h8000, 0);
        exp_q.push_back({24'h800000, 24'h800000});
        for (int k = 0; k < 4; k++) send(16'h7FFF, 0);

        // 4: overrun during WAIT and during MAC; dropped samples not accumulated
        chk("overrun_clear", overrun, 0);
        stub_sin = 16'h0000; stub_cos = 16'h0100;
        exp_q.push_back({24'd1600, 24'd0});
        send(16'd400, 2);
        chk("overrun_set", overrun, 1);
        send(16'd400, 0);
        send(16'd400, 5);
        send(16'd400, 0);
        chk("overrun_sticky", overrun, 1);

        // 5: phase-dependent DDS values
        ftw = 32'h12345678; use_func = 1'b1;
        v5 = '{16'd123, -16'sd457, 16'd2000, -16'sd31};
        p = exp_phase; ai = 0; aq = 0;
        for (int k = 0; k < 4; k++) begin
            ai += longint'($signed(v5[k])) * longint'(fcos(p[31:14]));
            aq += longint'($signed(v5[k])) * longint'(fsin(p[31:14]));
            p = p + ftw;
        end
        exp_q.push_back({sat24(ai), sat24(aq)});
        for (int k = 0; k < 4; k++) send(v5[k], 0);

        // 6: reset in the middle of a lookup discards the partial sum
        use_func = 1'b0; stub_sin = 16'h0000; stub_cos = 16'h7FFF;
        send(16'd1000, 0);
        send(16'd1000, 0);
        adc_data = 16'd1000; adc_valid = 1'b1;
        @(posedge clk); #1 adc_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_dds_go", dds_go, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_i_out", i_out, 0);
        chk("abort_q_out", q_out, 0);
        chk("abort_overrun", overrun, 0);
        chk("abort_dds_phase", dds_phase, 0);
        exp_phase = 32'h0;
        exp_q.push_back({24'd511984, 24'd0});
        for (int k = 0; k < 4; k++) send(16'd1000, 0);

        repeat (5) @(posedge clk);
        #2;
        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
